// File: rtl/if_id_stage.sv
// Fetch front end and IF/ID pipeline register: owns the PC, detects load-use
// hazards against ID/EX, applies MEM-stage branch redirects and keeps debug counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      pc4_out,
    output logic [31:0]      instr_out,
    output logic             valid_out,
    output logic             bubble_out,
    output logic             flush_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        hazard;

    assign imem_addr = {pc[31:2], 2'b00};
    assign pc_plus4  = pc + 32'd4;

    // Load in ID/EX writes a register the instruction in IF/ID reads.
    always_comb begin
        hazard = 1'b0;
        if (valid_out && id_ex_memread && (id_ex_rt != 5'd0) &&
            ((id_ex_rt == instr_out[25:21]) || (id_ex_rt == instr_out[20:16])))
            hazard = 1'b1;
    end

    assign bubble_out = hazard | branch_taken;
    assign flush_out  = branch_taken;

    // Redirect beats stall; a stalled cycle holds PC and IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            pc4_out   <= 32'd0;
            instr_out <= NOP;
            valid_out <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (branch_taken) begin
            pc        <= branch_target & 32'hFFFF_FFFC;
            pc4_out   <= 32'd0;
            instr_out <= NOP;
            valid_out <= 1'b0;
            if (flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (hazard) begin
            if (stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            pc        <= pc_plus4;
            pc4_out   <= pc_plus4;
            instr_out <= imem_data;
            valid_out <= 1'b1;
        end
    end

endmodule
